// File: rtl/transmitter.sv
// Serial frame transmitter: start bit (0), DATA_BITS data bits LSB first, stop bit (1).
// The line idles high and each bit lasts CLK_DIV clk cycles.
module transmitter #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_en,
  output logic                 dout,
  output logic                 tx_status,
  output logic                 tx_done
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 dout_q, dout_d;
  logic                 status_q, status_d;
  logic                 done_q, done_d;

  // Next-state and registered-output logic for the frame sequencer
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    status_d = status_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        bit_d    = '0;
        dout_d   = 1'b1;
        status_d = 1'b0;
        if (tx_en) begin
          shreg_d  = tx_data;
          state_d  = START;
          dout_d   = 1'b0;
          status_d = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          dout_d  = shreg_q[0];
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q < BIT_LAST) begin
            shreg_d = shreg_q >> 1'b1;
            bit_d   = bit_q + 1'b1;
            dout_d  = shreg_d[0];
          end else begin
            state_d = STOP;
            dout_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        dout_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d   = '0;
          state_d  = IDLE;
          status_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          baud_d   = baud_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        baud_d   = '0;
        bit_d    = '0;
        dout_d   = 1'b1;
        status_d = 1'b0;
      end
    endcase
  end

  // State register; reset wins over any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      dout_q   <= 1'b1;
      status_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign dout      = dout_q;
  assign tx_status = status_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench: two transmitters (CLK_DIV 4 and 2) share stimulus and are
// compared each cycle against a frame-offset reference model.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] dout_w, st_w, dn_w;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int         mdl_busy [2];
  int         mdl_t    [2];
  logic [7:0] mdl_data [2];
  logic [2:0] exp_o    [2];

  transmitter #(.CLK_DIV(4), .DATA_BITS(8)) u_dut4 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_en(tx_en),
    .dout(dout_w[0]), .tx_status(st_w[0]), .tx_done(dn_w[0]));

  transmitter #(.CLK_DIV(2), .DATA_BITS(8)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_en(tx_en),
    .dout(dout_w[1]), .tx_status(st_w[1]), .tx_done(dn_w[1]));

  always #5 clk = ~clk;

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int frame_len(int i);
    return 10 * div_of(i);
  endfunction

  // Line level for bit slot idx of a frame: 0 = start, 1..8 = data LSB first, else stop.
  function automatic logic line_bit(logic [7:0] d, int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else return 1'b1;
  endfunction

  function automatic logic [2:0] get_obs(int i);
    return {dout_w[i], st_w[i], dn_w[i]};
  endfunction

  // One clock edge; model tracks cycles elapsed since the accepting edge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      logic done_now;
      done_now = 1'b0;
      if (rst) begin
        mdl_busy[i] = 0;
      end else if (mdl_busy[i] == 0) begin
        if (tx_en) begin
          mdl_busy[i] = 1;
          mdl_t[i]    = 0;
          mdl_data[i] = tx_data;
        end
      end else begin
        mdl_t[i]++;
        if (mdl_t[i] == frame_len(i)) begin
          mdl_busy[i] = 0;
          done_now = 1'b1;
        end
      end
      exp_o[i] = (mdl_busy[i] != 0) ? {line_bit(mdl_data[i], mdl_t[i] / div_of(i)), 2'b10}
                                    : {2'b10, done_now};
    end
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    tx_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b1; tx_data = 8'hA5;
    repeat (2) begin
      step();
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== 3'b100) begin
          tests_failed++;
          $display("FAIL reset_hold inst%0d cyc%0d: got %b expected 100", i, cyc, get_obs(i));
        end
      end
    end
    rst = 1'b0; tx_en = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (get_obs(i) !== 3'b100) begin
        tests_failed++;
        $display("FAIL reset_release inst%0d: got %b expected 100", i, get_obs(i));
      end
    end
  endtask

  task automatic test_frame_a5();
    logic [9:0] pat;
    int st_cnt, dn_cnt, dn_at;
    pat = 10'b1101001010;
    st_cnt = 0; dn_cnt = 0; dn_at = -1;
    tx_data = 8'hA5; tx_en = 1'b1;
    for (int j = 0; j < 48; j++) begin
      step();
      tx_en = 1'b0;
      tx_data = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL frame_a5 inst%0d j%0d: got %b expected %b", i, j, get_obs(i), exp_o[i]);
        end
      end
      if (st_w[0]) st_cnt++;
      if (dn_w[0]) begin dn_cnt++; dn_at = j; end
      if (j < 40 && (j % 4) == 2) begin
        tests_run++;
        if (dout_w[0] !== pat[j/4]) begin
          tests_failed++;
          $display("FAIL frame_a5_bit slot%0d: got %b expected %b", j/4, dout_w[0], pat[j/4]);
        end
      end
    end
    tests_run++;
    if (st_cnt != 40 || dn_cnt != 1 || dn_at != 40) begin
      tests_failed++;
      $display("FAIL frame_a5_len: got status=%0d done=%0d at %0d expected 40 1 40", st_cnt, dn_cnt, dn_at);
    end
  endtask

  task automatic test_busy_ignore();
    int dn_cnt [2];
    dn_cnt = '{0, 0};
    tx_data = 8'h3C; tx_en = 1'b1;
    for (int j = 0; j < 48; j++) begin
      step();
      tx_en   = (j == 9);
      tx_data = (j == 9) ? 8'hFF : 8'h3C;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL busy_ignore inst%0d j%0d: got %b expected %b", i, j, get_obs(i), exp_o[i]);
        end
        if (dn_w[i]) dn_cnt[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (dn_cnt[i] != 1) begin
        tests_failed++;
        $display("FAIL busy_done_count inst%0d: got %0d expected 1", i, dn_cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   last_start [2];
    int   n_starts   [2];
    logic prev_st    [2];
    last_start = '{-1, -1};
    n_starts   = '{0, 0};
    prev_st    = '{1'b0, 1'b0};
    tx_data = 8'h01; tx_en = 1'b1;
    for (int j = 0; j < 130; j++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL back_to_back inst%0d j%0d: got %b expected %b", i, j, get_obs(i), exp_o[i]);
        end
        if (st_w[i] && !prev_st[i]) begin
          if (last_start[i] >= 0) begin
            tests_run++;
            if (j - last_start[i] != frame_len(i) + 1) begin
              tests_failed++;
              $display("FAIL b2b_spacing inst%0d: got %0d expected %0d", i, j - last_start[i], frame_len(i) + 1);
            end
          end
          last_start[i] = j;
          n_starts[i]++;
        end
        prev_st[i] = st_w[i];
      end
    end
    tests_run++;
    if (n_starts[0] < 3) begin
      tests_failed++;
      $display("FAIL b2b_starts: got %0d expected at least 3", n_starts[0]);
    end
    idle(45);
  endtask

  task automatic test_mid_reset();
    int st_cnt, dn_cnt;
    st_cnt = 0; dn_cnt = 0;
    tx_data = 8'h00; tx_en = 1'b1;
    for (int j = 0; j < 17; j++) begin
      step();
      tx_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL mid_reset_pre inst%0d j%0d: got %b expected %b", i, j, get_obs(i), exp_o[i]);
        end
      end
    end
    rst = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (get_obs(i) !== 3'b100) begin
        tests_failed++;
        $display("FAIL mid_reset_abort inst%0d: got %b expected 100", i, get_obs(i));
      end
    end
    rst = 1'b0; tx_en = 1'b1; tx_data = 8'($urandom);
    for (int j = 0; j < 48; j++) begin
      step();
      tx_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL mid_reset_post inst%0d j%0d: got %b expected %b", i, j, get_obs(i), exp_o[i]);
        end
      end
      if (st_w[0]) st_cnt++;
      if (dn_w[0]) dn_cnt++;
    end
    tests_run++;
    if (st_cnt != 40 || dn_cnt != 1) begin
      tests_failed++;
      $display("FAIL mid_reset_frame: got status=%0d done=%0d expected 40 1", st_cnt, dn_cnt);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] vals [2];
    vals = '{8'hFF, 8'h00};
    for (int v = 0; v < 2; v++) begin
      int st_cnt, zero_cnt, dn_at;
      st_cnt = 0; zero_cnt = 0; dn_at = -1;
      idle(45);
      tx_data = vals[v]; tx_en = 1'b1;
      for (int j = 0; j < 25; j++) begin
        step();
        tx_en = 1'b0;
        tests_run++;
        if (get_obs(1) !== exp_o[1]) begin
          tests_failed++;
          $display("FAIL boundary inst1 data%h j%0d: got %b expected %b", vals[v], j, get_obs(1), exp_o[1]);
        end
        if (st_w[1]) st_cnt++;
        if (!dout_w[1]) zero_cnt++;
        if (dn_w[1]) dn_at = j;
      end
      tests_run++;
      if (st_cnt != 20 || dn_at != 20 || zero_cnt != 2 * (9 - $countones(vals[v]))) begin
        tests_failed++;
        $display("FAIL boundary_len data%h: got status=%0d done_at=%0d zeros=%0d expected 20 20 %0d",
                 vals[v], st_cnt, dn_at, zero_cnt, 2 * (9 - $countones(vals[v])));
      end
    end
    idle(45);
  endtask

  task automatic test_random();
    for (int j = 0; j < 800; j++) begin
      tx_en   = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      rst     = ($urandom_range(0, 199) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (get_obs(i) !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL random inst%0d cyc%0d: got %b expected %b", i, cyc, get_obs(i), exp_o[i]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    mdl_busy = '{0, 0};
    mdl_t    = '{0, 0};
    test_reset();
    test_frame_a5();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
